// File: rtl/core_bus_arbiter.sv
// rtl/core_bus_arbiter.sv - round-robin arbiter sharing the core bus between requesters
//
// Grants one requester at a time, drives its instruction/address/value onto
// the core bus for one issue cycle, waits RESULT_LATENCY cycles, captures the
// bus result and pulses ack_o to the owner.
//
// Ports:
//   clk, rst_n                  system clock, asynchronous active-low reset
//   req_i[NUM_REQ]              per-requester request level
//   req_instr_i/addr_i/value_i  per-requester payload, requester k in slice k
//   grant_o[NUM_REQ]            one-hot owner during ISSUE/WAIT/RESP
//   ack_o[NUM_REQ]              one-cycle completion pulse to the owner
//   result_o[32]                captured bus result, valid with ack_o
//   bus_instruction_o/address_o/value_o  core bus drive
//   bus_result_i[32]            core bus result
//   busy_o                      high whenever not IDLE
//   lock_i[NUM_REQ]             only with ARB_LOCK_EN: owner keeps the bus
//
// Optional feature macro: ARB_LOCK_EN

module core_bus_arbiter #(
    parameter int         NUM_REQ        = 2,
    parameter int         RESULT_LATENCY = 2,
    parameter logic [7:0] NOP_INSTR      = 8'h00
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [8*NUM_REQ-1:0]    req_instr_i,
    input  logic [24*NUM_REQ-1:0]   req_addr_i,
    input  logic [32*NUM_REQ-1:0]   req_value_i,
`ifdef ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]      lock_i,
`endif
    output logic [NUM_REQ-1:0]      grant_o,
    output logic [NUM_REQ-1:0]      ack_o,
    output logic [31:0]             result_o,
    output logic [7:0]              bus_instruction_o,
    output logic [23:0]             bus_address_o,
    output logic [31:0]             bus_value_o,
    input  logic [31:0]             bus_result_i,
    output logic                    busy_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]         state;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      owner;
    logic [3:0]         wait_cnt;
    logic [NUM_REQ-1:0] cand;
    logic               found;
    logic [PW-1:0]      sel;
    int                 idx;
    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] sel_oh;
    logic [PW-1:0]      owner_next;

    assign owner_oh   = NUM_REQ'(1) << owner;
    assign sel_oh     = NUM_REQ'(1) << sel;
    assign owner_next = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + PW'(1);
    assign busy_o     = (state != S_IDLE);

`ifdef ARB_LOCK_EN
    logic locked;
    logic lock_hold;
    // While the previous owner still holds its lock, nobody else may win.
    assign lock_hold = locked && ((lock_i & owner_oh) != '0);
`endif

    // First requesting index scanning upward from rr_ptr with wrap.
    always_comb begin
        cand = req_i;
`ifdef ARB_LOCK_EN
        if (lock_hold) cand = req_i & owner_oh;
`endif
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && cand[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            rr_ptr            <= '0;
            owner             <= '0;
            wait_cnt          <= '0;
            grant_o           <= '0;
            ack_o             <= '0;
            result_o          <= '0;
            bus_instruction_o <= NOP_INSTR;
            bus_address_o     <= '0;
            bus_value_o       <= '0;
`ifdef ARB_LOCK_EN
            locked            <= 1'b0;
`endif
        end else begin
            ack_o <= '0;
            case (state)
                S_IDLE: begin
                    bus_instruction_o <= NOP_INSTR;
                    if (found) begin
                        owner             <= sel;
                        grant_o           <= sel_oh;
                        bus_instruction_o <= req_instr_i[8*sel +: 8];
                        bus_address_o     <= req_addr_i[24*sel +: 24];
                        bus_value_o       <= req_value_i[32*sel +: 32];
                        state             <= S_ISSUE;
`ifdef ARB_LOCK_EN
                        locked            <= 1'b0;
`endif
                    end else begin
`ifdef ARB_LOCK_EN
                        if (!lock_hold) begin
                            locked  <= 1'b0;
                            grant_o <= '0;
                        end
`else
                        grant_o <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    // Instruction is a single-cycle strobe; address/value stay put.
                    bus_instruction_o <= NOP_INSTR;
                    wait_cnt          <= 4'(RESULT_LATENCY - 1);
                    state             <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        result_o <= bus_result_i;
                        ack_o    <= owner_oh;
                        state    <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
`ifdef ARB_LOCK_EN
                    if ((lock_i & owner_oh) != '0) begin
                        locked <= 1'b1;
                    end else begin
                        grant_o <= '0;
                        rr_ptr  <= owner_next;
                    end
`else
                    grant_o <= '0;
                    rr_ptr  <= owner_next;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb/tb_core_bus_arbiter.sv - scoreboard bench for core_bus_arbiter

module tb_core_bus_arbiter;

    localparam int N  = 3;
    localparam int RL = 2;

    typedef struct {
        int          req;
        logic [31:0] res;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req_i;
    logic [8*N-1:0]     req_instr_i;
    logic [24*N-1:0]    req_addr_i;
    logic [32*N-1:0]    req_value_i;
`ifdef ARB_LOCK_EN
    logic [N-1:0]       lock_i;
`endif
    logic [N-1:0]       grant_o;
    logic [N-1:0]       ack_o;
    logic [31:0]        result_o;
    logic [7:0]         bus_instruction_o;
    logic [23:0]        bus_address_o;
    logic [31:0]        bus_value_o;
    logic [31:0]        bus_result_i = 32'h0;
    logic               busy_o;

    core_bus_arbiter #(.NUM_REQ(N), .RESULT_LATENCY(RL), .NOP_INSTR(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i),
        .req_instr_i(req_instr_i), .req_addr_i(req_addr_i), .req_value_i(req_value_i),
`ifdef ARB_LOCK_EN
        .lock_i(lock_i),
`endif
        .grant_o(grant_o), .ack_o(ack_o), .result_o(result_o),
        .bus_instruction_o(bus_instruction_o), .bus_address_o(bus_address_o),
        .bus_value_o(bus_value_o), .bus_result_i(bus_result_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    int          model_ptr = 0;
    logic [7:0]  pay_instr[N];
    logic [23:0] pay_addr[N];
    logic [31:0] pay_val[N];
    int          p_drop = 0;
    int          p_chg = 0;
    logic        use_fixed = 1'b0;
    logic [31:0] fixed_res = 32'h0;
    int          issue_cyc = -100;
    logic [31:0] pend_res = 32'h0;
    logic        prev_active = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] hash(input logic [7:0] i, input logic [23:0] a, input logic [31:0] v);
        if (use_fixed) return fixed_res;
        return (v ^ {a, i}) + 32'h1234_5678;
    endfunction

    // Core-side model plus scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_instruction_o != 8'h00) begin
                chk("instr_one_cycle", 32'(prev_active), 32'd0);
                issue_cyc = cyc;
                pend_res  = hash(bus_instruction_o, bus_address_o, bus_value_o);
            end
            prev_active  = (bus_instruction_o != 8'h00);
            bus_result_i = (cyc == issue_cyc + RL) ? pend_res : 32'hDEAD_BEEF;
            if (busy_o) chk("grant_onehot", 32'($onehot(grant_o)), 32'd1);
            if (ack_o != '0) begin
                if (exp_q.size() == 0) begin
                    chk("ack_unexpected", 32'(ack_o), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ack_owner", 32'(ack_o), 32'(1 << e.req));
                    chk("result", result_o, e.res);
                    chk("ack_latency", 32'(cyc - issue_cyc), 32'(RL + 1));
                end
            end
        end else begin
            prev_active = 1'b0;
        end
    end

    task automatic drive_payload(input int k);
        req_instr_i[8*k +: 8]   = pay_instr[k];
        req_addr_i[24*k +: 24]  = pay_addr[k];
        req_value_i[32*k +: 32] = pay_val[k];
    endtask

    task automatic randomize_payloads();
        for (int k = 0; k < N; k++) begin
            pay_instr[k] = 8'($urandom_range(1, 255));
            pay_addr[k]  = 24'($urandom);
            pay_val[k]   = $urandom;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, 32'(grant_o), 32'd0);
        chk({tag, "_ack"}, 32'(ack_o), 32'd0);
        chk({tag, "_result"}, result_o, 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_instr"}, 32'(bus_instruction_o), 32'h00);
        chk({tag, "_addr"}, 32'(bus_address_o), 32'd0);
        chk({tag, "_value"}, bus_value_o, 32'd0);
    endtask

    // All requesters in 'set' raise req together and hold until acked.
    // Service order is the set taken cyclically from the round-robin pointer.
    task automatic run_round(input logic [N-1:0] set);
        logic [N-1:0] done, seen;
        int p, last, k, t;
        exp_t e;
        p = model_ptr;
        last = p;
        for (int i = 0; i < N; i++) begin
            k = (p + i) % N;
            if (set[k]) begin
                e.req = k;
                e.res = hash(pay_instr[k], pay_addr[k], pay_val[k]);
                exp_q.push_back(e);
                last = k;
            end
        end
        model_ptr = (last + 1) % N;
        @(negedge clk);
        for (int j = 0; j < N; j++) drive_payload(j);
        req_i = set;
        done = '0;
        seen = '0;
        t = 0;
        while (done != set && t < 200) begin
            @(negedge clk);
            t++;
            for (int j = 0; j < N; j++) begin
                if (ack_o[j]) begin
                    done[j] = 1'b1;
                    req_i[j] = 1'b0;
                end else if (grant_o[j] && !seen[j]) begin
                    seen[j] = 1'b1;
                    if (int'($urandom_range(0, 99)) < p_drop) req_i[j] = 1'b0;
                    if (int'($urandom_range(0, 99)) < p_chg) begin
                        req_instr_i[8*j +: 8]   = pay_instr[j] ^ 8'h55;
                        req_addr_i[24*j +: 24]  = pay_addr[j] ^ 24'h1;
                        req_value_i[32*j +: 32] = pay_val[j] + 32'h11;
                    end
                end
            end
        end
        if (done != set) chk("round_timeout", 32'(done), 32'(set));
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        req_i = '0;
        req_instr_i = '0;
        req_addr_i = '0;
        req_value_i = '0;
`ifdef ARB_LOCK_EN
        lock_i = '0;
`endif
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single request with fixed bus result.
        randomize_payloads();
        pay_instr[0] = 8'h02;
        pay_addr[0]  = 24'h000001;
        pay_val[0]   = 32'h0000_0005;
        use_fixed    = 1'b1;
        fixed_res    = 32'h0000_000C;
        run_round(3'b001);
        use_fixed    = 1'b0;

        // Payload altered after grant must not reach the bus.
        randomize_payloads();
        pay_val[1] = 32'h0000_0011;
        p_chg = 100;
        run_round(3'b010);
        p_chg = 0;

        // Simultaneous held requests.
        randomize_payloads();
        run_round(3'b111);
        randomize_payloads();
        run_round(3'b011);

        // Requesters drop req while their transaction is in flight.
        randomize_payloads();
        p_drop = 100;
        run_round(3'b011);
        p_drop = 0;

        // Random rounds.
        p_drop = 25;
        p_chg  = 25;
        for (int r = 0; r < 40; r++) begin
            randomize_payloads();
            run_round(N'($urandom_range(1, (1 << N) - 1)));
        end
        p_drop = 0;
        p_chg  = 0;

`ifdef ARB_LOCK_EN
        begin
            int n0;
            logic added1;
            exp_t e;
            randomize_payloads();
            for (int i = 0; i < 3; i++) begin
                e.req = 0;
                e.res = hash(pay_instr[0], pay_addr[0], pay_val[0]);
                exp_q.push_back(e);
            end
            e.req = 1;
            e.res = hash(pay_instr[1], pay_addr[1], pay_val[1]);
            exp_q.push_back(e);
            model_ptr = 2;
            @(negedge clk);
            for (int j = 0; j < N; j++) drive_payload(j);
            lock_i = 3'b001;
            req_i  = 3'b001;
            n0 = 0;
            added1 = 1'b0;
            t = 0;
            while ((n0 < 3 || req_i[1]) && t < 300) begin
                @(negedge clk);
                t++;
                if (grant_o[0] && !added1) begin
                    req_i[1] = 1'b1;
                    added1 = 1'b1;
                end
                if (ack_o[0]) begin
                    n0++;
                    if (n0 == 3) begin
                        lock_i[0] = 1'b0;
                        req_i[0]  = 1'b0;
                    end
                end
                if (ack_o[1]) req_i[1] = 1'b0;
            end
            chk("lock_timeout", 32'(t < 300), 32'd1);
        end
`endif

        // Reset asserted in WAIT: outputs return to reset values, no ack.
        randomize_payloads();
        @(negedge clk);
        for (int j = 0; j < N; j++) drive_payload(j);
        req_i = 3'b100;
        t = 0;
        while (bus_instruction_o == 8'h00 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("reset_test_issue_seen", 32'(t < 50), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midwait_reset");
        req_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;

        // Pointer must restart from requester 0 after reset.
        randomize_payloads();
        run_round(3'b111);

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Shares the internal core bus between NUM_REQ requesters, e.g. the SPI instruction handler and a local test sequencer. The bus is the 8-bit instruction, 24-bit address, 32-bit value and 32-bit result lanes into the core_interface instances.
- Grants one requester at a time, round-robin. Drives one bus transaction, waits a fixed result latency, captures the result and returns an ack.
- Sits between the requesters and the core_interface bus. Runs on the system clock.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- RESULT_LATENCY, 2, cycles from instruction issue until bus_result_i is valid (1..15).
- NOP_INSTR, 8'h00, instruction driven when the bus is idle.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_i  input  NUM_REQ  per-requester request level.
- req_instr_i  input  8*NUM_REQ  per-requester instruction; requester k in bits [8k+7:8k].
- req_addr_i  input  24*NUM_REQ  per-requester address.
- req_value_i  input  32*NUM_REQ  per-requester write value.
- grant_o  output  NUM_REQ  one-hot; current owner during ISSUE/WAIT/RESP.
- ack_o  output  NUM_REQ  one-cycle pulse to the owner when the transaction completes.
- result_o  output  32  captured bus result; valid with ack_o, held until the next capture.
- bus_instruction_o  output  8  to core_interface instruction.
- bus_address_o  output  24  to core_interface address.
- bus_value_o  output  32  to core_interface value.
- bus_result_i  input  32  from core_interface output_value.
- busy_o  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE, rr_ptr=0, grant_o=0, ack_o=0, result_o=0, busy_o=0.
  - bus_instruction_o=NOP_INSTR, bus_address_o=0, bus_value_o=0.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_i is set, select the first set bit scanning from rr_ptr upward with wrap.
  - Register grant, latch that requester's instr/addr/value into the bus output registers, go to ISSUE.
  - Otherwise the bus holds NOP_INSTR.
- ISSUE (1 cycle):
  - Bus outputs carry the latched transaction.
  - Next cycle: bus_instruction_o returns to NOP_INSTR; address and value are held.
  - Load wait counter with RESULT_LATENCY-1, go to WAIT.
- WAIT: decrement the counter. When it reaches 0, capture bus_result_i into result_o and go to RESP.
- RESP (1 cycle):
  - ack_o[owner]=1.
  - rr_ptr = owner+1, wrapping at NUM_REQ.
  - Clear grant_o, go to IDLE.
- Latency: req sampled in IDLE at cycle t -> ISSUE at t+1 -> ack_o at t+2+RESULT_LATENCY. A back-to-back request from another requester is granted in the cycle after RESP.
- Payload is latched at grant. Requester changes to instr/addr/value after the grant cycle have no effect.
- Requester drops req_i mid-transaction: the transaction still completes and ack_o still pulses.
- Requester must deassert req_i in the cycle after ack, or it competes again at lowest round-robin priority.
- Simultaneous requests: only one grant; the others wait. Fairness: every asserted requester is served within NUM_REQ transactions.
- Only req_i bits with index < NUM_REQ exist. rr_ptr never exceeds NUM_REQ-1.
- Reset asserted mid-transaction: immediate return to reset values; no ack issued.

Optional Feature:
- Macro: ARB_LOCK_EN. Adds input lock_i [NUM_REQ].
- With macro, if lock_i[owner] is high during RESP:
  - ack still pulses and rr_ptr is not advanced.
  - The owner keeps the grant; the next IDLE cycle considers only that requester while lock_i[owner] stays high.
  - Used for multi-word writes to one core.
- Without macro: lock_i does not exist; pure round-robin as above.

Test Plan:
- Reset with rst_n=0 mid-WAIT -> all outputs reset within the same cycle, bus_instruction_o=8'h00, no ack_o.
- Single request: req_i=2'b01, instr=8'h02, addr=24'h000001, value=32'h0000_0005, bus_result_i=32'h0000_000C, RESULT_LATENCY=2 -> bus_instruction_o=8'h02 for exactly 1 cycle; ack_o=2'b01 at t+4; result_o=32'h0000_000C.
- Simultaneous req_i=2'b11 held -> grants alternate 0,1,0,1 over 4 transactions; no cycle with two grant bits set.
- Req 1 drops req_i in WAIT -> ack_o[1] still pulses; next grant goes to req 0 if it is pending.
- Payload changed after grant (value 32'h11 -> 32'h22) -> bus_value_o stays 32'h11 for the whole transaction.
- ARB_LOCK_EN: req 0 holds lock_i[0]=1 for 3 transactions while req_i[1]=1 -> three consecutive acks to 0, then grant to 1 after the lock drops.
